uncache_axi_bridge: RTL and testbench

- Single-outstanding AXI4 master. Converts the uncached-access request bus (axi_en/axi_wsel/axi_addr/axi_wdata) into one AXI4 single-beat read or write transaction.
- Returns completion as a one-cycle reload pulse. For reads, it also returns axi_rdata.
- Sits directly downstream of the uncache request stage and upstream of the SoC AXI interconnect.

---
 rtl/uncache_axi_bridge_pkg.sv | 25 ++
 rtl/uncache_axi_bridge_if.sv | 72 +++++++
 rtl/uncache_axi_bridge.sv | 162 ++++++++++++++++
 tb/tb_uncache_axi_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uncache_axi_bridge_pkg.sv
// Shared definitions for the uncached-access AXI4 bridge: FSM states,
// fixed AXI attribute encodings and a response classifier.
package uncache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    localparam logic [7:0] LEN_SINGLE   = 8'd0;
    localparam logic [2:0] SIZE_4B      = 3'b010;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [3:0] CACHE_DEVICE = 4'b0000;
    localparam logic [2:0] PROT_DATA    = 3'b000;

    // Anything other than OKAY counts as a bus error.
    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// AXI4 single-ID bus bundle used between the bridge (master) and the
// SoC interconnect (slave).
interface uncache_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/uncache_axi_bridge.sv
// Single-outstanding AXI4 master turning one uncached request into one
// single-beat read or write, completing with a one-cycle reload pulse.
// Optional feature macro: UNCACHE_BRIDGE_ERR_EN (sticky bus_err on any
// non-OKAY read/write response).
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        axi_en,
    input  logic [3:0]  axi_wsel,
    input  logic [31:0] axi_addr,
    input  logic [31:0] axi_wdata,
    output logic        reload,
    output logic [31:0] axi_rdata,
    output logic        bus_err,
    uncache_axi_bridge_if.master axi
);

    state_t      state;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        aw_done, w_done;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = arvalid_q & axi.arready;
    assign r_hs  = rready_q  & axi.rvalid;
    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q  & axi.wready;
    assign b_hs  = bready_q  & axi.bvalid;

    // Fixed single-beat, 4-byte, device-type attributes.
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = CACHE_DEVICE;
    assign axi.arprot  = PROT_DATA;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = CACHE_DEVICE;
    assign axi.awprot  = PROT_DATA;
    assign axi.awvalid = awvalid_q;

    // Single beat: the only beat is always the last one.
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // IDs and rlast carry no information for a single-outstanding single beat.
    logic unused_resp;
    assign unused_resp = &{1'b0, axi.rid, axi.rlast, axi.bid, axi.rresp, axi.bresp};

    // Transaction FSM; all handshake outputs are registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            reload    <= 1'b0;
            axi_rdata <= '0;
        end else begin
            reload <= 1'b0;
            case (state)
                IDLE: begin
                    // Upstream still holds axi_en during the reload cycle;
                    // the reload guard stops that request being issued twice.
                    if (axi_en && !reload) begin
                        addr_q <= axi_addr;
                        if (axi_wsel == 4'b0000) begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wstrb_q   <= axi_wsel;
                            wdata_q   <= axi_wdata;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        axi_rdata <= axi.rdata;
                        reload    <= 1'b1;
                        rready_q  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; same-cycle completion
                    // is covered by folding in this cycle's handshakes.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        reload   <= 1'b1;
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UNCACHE_BRIDGE_ERR_EN
    // Sticky error flag: any accepted non-OKAY response since reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus_err <= 1'b0;
        else if ((r_hs && resp_err(axi.rresp)) || (b_hs && resp_err(axi.bresp)))
            bus_err <= 1'b1;
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Randomized self-checking bench for uncache_axi_bridge. The bench plays
// both the upstream requester and the AXI slave; expectations come from a
// small transaction-level model (expected data, sticky error, latency).
module tb_uncache_axi_bridge;

`ifdef UNCACHE_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        axi_en;
    logic [3:0]  axi_wsel;
    logic [31:0] axi_addr, axi_wdata;
    logic        reload;
    logic [31:0] axi_rdata;
    logic        bus_err;

    uncache_axi_bridge_if #(.ID_W(4)) axi ();

    uncache_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .axi_en    (axi_en),
        .axi_wsel  (axi_wsel),
        .axi_addr  (axi_addr),
        .axi_wdata (axi_wdata),
        .reload    (reload),
        .axi_rdata (axi_rdata),
        .bus_err   (bus_err),
        .axi       (axi.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        if ($urandom_range(0, 5) == 0) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    task automatic note_resp(input logic [1:0] resp);
        if (ERR_EN && resp != 2'b00) exp_err = 1'b1;
    endtask

    // Upstream drops axi_en only after it has seen reload; nothing new may issue.
    task automatic finish_txn();
        @(posedge clk);
        #1;
        axi_en   = 1'b0;
        axi_wsel = 4'($urandom);
        axi_addr = $urandom;
        @(negedge clk);
        chk("no_reissue", {reload, axi.arvalid, axi.awvalid, axi.wvalid}, 4'b0000);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_dly, input int r_dly);
        int t0;
        axi_en = 1'b1; axi_wsel = 4'b0000; axi_addr = addr; axi_wdata = $urandom;
        t0 = cyc;
        @(negedge clk);
        axi_addr = $urandom;  // must be ignored after accept
        chk("ar_first", {axi.arvalid, axi.rready, axi.araddr}, {1'b1, 1'b0, addr});
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            chk("ar_hold", {axi.arvalid, axi.rready, axi.araddr}, {1'b1, 1'b0, addr});
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        chk("ar_drop", {axi.arvalid, axi.rready}, 2'b01);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("r_wait", {axi.arvalid, axi.rready, reload}, 3'b010);
        end
        axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp;
        axi.rid = 4'($urandom); axi.rlast = 1'($urandom);
        @(negedge clk);
        axi.rvalid = 1'b0; axi.rdata = $urandom; axi.rresp = 2'b00;
        exp_rdata = data;
        note_resp(resp);
        chk("rd_reload", {reload, axi.rready, axi.arvalid}, 3'b100);
        chk("rd_data", axi_rdata, exp_rdata);
        chk("rd_lat", cyc - t0, ar_dly + r_dly + 3);
        chk("bus_err", bus_err, exp_err);
        finish_txn();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] wsel, input logic [31:0] data,
                            input logic [1:0] resp, input int aw_dly, input int w_dly, input int b_dly);
        int t0;
        bit aw_d, w_d, aw_hs, w_hs;
        aw_d = 1'b0; w_d = 1'b0;
        axi_en = 1'b1; axi_wsel = wsel; axi_addr = addr; axi_wdata = data;
        t0 = cyc;
        @(negedge clk);
        axi_addr = $urandom; axi_wdata = $urandom; axi_wsel = 4'($urandom_range(1, 15));
        for (int i = 0; i < 16 && !(aw_d && w_d); i++) begin
            chk("aw_valid", axi.awvalid, !aw_d);
            chk("w_valid", axi.wvalid, !w_d);
            chk("wlast", axi.wlast, !w_d);
            chk("b_early", axi.bready, 0);
            if (!aw_d) chk("aw_addr", axi.awaddr, addr);
            if (!w_d)  chk("w_payload", {axi.wstrb, axi.wdata}, {wsel, data});
            // Readies stay up once raised, so any re-asserted valid would show.
            axi.awready = (i >= aw_dly);
            axi.wready  = (i >= w_dly);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(negedge clk);
            if (aw_hs) aw_d = 1'b1;
            if (w_hs)  w_d  = 1'b1;
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        chk("wr_both_done", {aw_d, w_d}, 2'b11);
        for (int i = 0; i < b_dly; i++) begin
            chk("b_wait", {axi.bready, axi.awvalid, axi.wvalid, reload}, 4'b1000);
            @(negedge clk);
        end
        chk("b_ready", axi.bready, 1);
        axi.bvalid = 1'b1; axi.bresp = resp; axi.bid = 4'($urandom);
        @(negedge clk);
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        note_resp(resp);
        chk("wr_reload", {reload, axi.bready, axi.awvalid, axi.wvalid}, 4'b1000);
        chk("wr_rdata_kept", axi_rdata, exp_rdata);
        chk("wr_lat", cyc - t0, ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3);
        chk("bus_err", bus_err, exp_err);
        finish_txn();
    endtask

    initial begin
        resetn = 1'b0;
        axi_en = 1'b0; axi_wsel = 4'b0; axi_addr = '0; axi_wdata = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.rid = '0; axi.rlast = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        exp_rdata = '0; exp_err = 1'b0;

        // Reset state and constant attributes
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {reload, bus_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 7'b0);
        chk("rst_rdata", axi_rdata, 32'h0);
        chk("rst_addr", {axi.araddr, axi.awaddr}, 64'h0);
        chk("rst_w", {axi.wdata, axi.wstrb}, 36'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {axi.arvalid, axi.awvalid, axi.wvalid, reload}, 4'b0000);
        chk("ar_attr", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
            {4'd1, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0000, 3'b000});
        chk("aw_attr", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
            {4'd1, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0000, 3'b000});

        // Delayed AR and R
        do_read(32'h8000_0010, 32'h1234_5678, 2'b00, 3, 2);
        // W accepted two cycles before AW
        do_write(32'h1FAF_FFF0, 4'b0011, 32'h0000_A5A5, 2'b00, 3, 1, 1);
        // AW and W in the same cycle, zero-wait B: reload 3 cycles after accept
        do_write(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
        // Minimum-latency read
        do_read(32'h0000_0200, 32'hCAFE_F00D, 2'b00, 0, 0);
        // Error response, then OKAY traffic: error flag (if built in) stays set
        do_read(32'h0000_0300, 32'h0BAD_0BAD, 2'b10, 1, 0);
        do_write(32'h0000_0304, 4'b1000, 32'h1111_2222, 2'b00, 1, 0, 2);
        do_read(32'h0000_0308, 32'h3333_4444, 2'b00, 0, 1);

        // Asynchronous reset while waiting for R
        axi_en = 1'b1; axi_wsel = 4'b0000; axi_addr = 32'h0000_0400;
        @(negedge clk);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        axi_en = 1'b0;
        chk("rst_pre_rdata", axi.rready, 1);
        #2 resetn = 1'b0;
        #1;
        exp_err = 1'b0;
        exp_rdata = '0;
        chk("rst_async", {axi.arvalid, axi.rready, reload, axi.awvalid, axi.wvalid, axi.bready}, 6'b0);
        chk("rst_async_err", bus_err, exp_err);
        chk("rst_async_rdata", axi_rdata, exp_rdata);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {axi.arvalid, axi.rready, reload}, 3'b000);
        do_read(32'h0000_0500, 32'h5555_AAAA, 2'b00, 1, 1);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_read($urandom, $urandom, pick_resp(), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_write($urandom, 4'($urandom_range(1, 15)), $urandom, pick_resp(),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
